// File: rtl/decoder_seq_nto2n.sv
// Registered N-to-2^N decoder with STATIC, PULSE and SCAN modes.
// Every output is a flop fed from a single next-state decision, so at most
// one line can ever be asserted and all outputs change together.
module decoder_seq_nto2n #(
   parameter int   SEL_W      = 2,
   parameter bit   ACTIVE_LOW = 1'b1,
   parameter int   DWELL_W    = 4,
   localparam int  OUT_W      = 2**SEL_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [1:0]         mode,
   input  logic [SEL_W-1:0]   sel,
   input  logic               load,
   input  logic [DWELL_W-1:0] dwell,
   output logic [OUT_W-1:0]   y,
   output logic [SEL_W-1:0]   active_idx,
   output logic               valid,
   output logic               wrap
);

   localparam logic [OUT_W-1:0] IDLE_PAT = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
   localparam logic [OUT_W-1:0] ONE_HOT0 = {{(OUT_W-1){1'b0}}, 1'b1};
   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_W-1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STATIC = 2'd1,
      S_PULSE  = 2'd2,
      S_SCAN   = 2'd3
   } state_t;

   state_t             state, state_nxt;
   logic               armed;
   logic [SEL_W-1:0]   scan_idx, scan_idx_nxt;
   logic [DWELL_W-1:0] cnt, cnt_nxt;
   logic [DWELL_W-1:0] dwell_lat, dwell_lat_nxt;
   logic               wrap_nxt;
   logic [SEL_W-1:0]   line_nxt;
   logic               assert_nxt;
   logic [OUT_W-1:0]   y_nxt;

   // Hold off decoding for the first edge after reset release so a release
   // close to an edge can never produce a partial or spurious strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) armed <= 1'b0;
      else        armed <= 1'b1;
   end

   // Next-state decision: mode and enable are re-evaluated on every edge.
   always_comb begin
      state_nxt = S_IDLE;
      if (armed && en) begin
         case (mode)
            2'b00:   state_nxt = S_STATIC;
            2'b01:   state_nxt = load ? S_PULSE : S_IDLE;
            2'b10:   state_nxt = S_SCAN;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // Scan sequencer: fresh start on entry, otherwise count the dwell and
   // step the index; dwell is only re-latched at the frame wrap. The counter
   // stops at the latched dwell, so it never exceeds its own range.
   always_comb begin
      scan_idx_nxt  = '0;
      cnt_nxt       = '0;
      dwell_lat_nxt = dwell_lat;
      wrap_nxt      = 1'b0;
      if (state_nxt == S_SCAN) begin
         if (state != S_SCAN) begin
            dwell_lat_nxt = dwell;
         end else if (cnt == dwell_lat) begin
            scan_idx_nxt = scan_idx + SEL_W'(1);
            if (scan_idx == LAST_IDX) begin
               wrap_nxt      = 1'b1;
               dwell_lat_nxt = dwell;
            end
         end else begin
            scan_idx_nxt = scan_idx;
            cnt_nxt      = cnt + DWELL_W'(1);
         end
      end
   end

   // Output decode: pick the line, build the one-hot, apply polarity.
   always_comb begin
      assert_nxt = (state_nxt != S_IDLE);
      line_nxt   = (state_nxt == S_SCAN) ? scan_idx_nxt : sel;
      y_nxt      = assert_nxt ? (ONE_HOT0 << line_nxt) : '0;
      if (ACTIVE_LOW) y_nxt = ~y_nxt;
   end

   // State and sequencer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         scan_idx  <= '0;
         cnt       <= '0;
         dwell_lat <= '0;
      end else begin
         state     <= state_nxt;
         scan_idx  <= scan_idx_nxt;
         cnt       <= cnt_nxt;
         dwell_lat <= dwell_lat_nxt;
      end
   end

   // Registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y          <= IDLE_PAT;
         active_idx <= '0;
         valid      <= 1'b0;
         wrap       <= 1'b0;
      end else begin
         y          <= y_nxt;
         active_idx <= assert_nxt ? line_nxt : '0;
         valid      <= assert_nxt;
         wrap       <= wrap_nxt;
      end
   end

endmodule

// File: tb/tb_decoder_seq_nto2n.sv
// Bench for decoder_seq_nto2n: two instances (2-to-4 active-low and 3-to-8
// active-high) driven in parallel, checked every cycle against a frame-level
// model plus literal expectations in the directed sequence.
module tb_decoder_seq_nto2n;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       load = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [1:0] sel_a = '0;
   logic [2:0] sel_b = '0;
   logic [3:0] dwell = '0;

   logic [3:0] y_a;
   logic [1:0] idx_a;
   logic       valid_a, wrap_a;
   logic [7:0] y_b;
   logic [2:0] idx_b;
   logic       valid_b, wrap_b;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   decoder_seq_nto2n #(.SEL_W(2), .ACTIVE_LOW(1'b1), .DWELL_W(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel_a), .load(load),
      .dwell(dwell), .y(y_a), .active_idx(idx_a), .valid(valid_a), .wrap(wrap_a));

   decoder_seq_nto2n #(.SEL_W(3), .ACTIVE_LOW(1'b0), .DWELL_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel_b), .load(load),
      .dwell(dwell), .y(y_b), .active_idx(idx_b), .valid(valid_b), .wrap(wrap_b));

   // Model: kind 0 idle, 1 static, 2 pulse, 3 scan; p = cycle position in
   // the current scan frame, d = dwell in force for this frame.
   typedef struct {
      bit armed;
      int kind;
      int line;
      bit wrap;
      int p;
      int d;
   } mdl_t;

   mdl_t ma, mb;

   function automatic mdl_t mdl_reset();
      mdl_t r;
      r.armed = 0; r.kind = 0; r.line = 0; r.wrap = 0; r.p = 0; r.d = 0;
      return r;
   endfunction

   function automatic mdl_t step(mdl_t m, int outw, int s);
      mdl_t n = m;
      n.wrap = 0;
      if (!m.armed) begin
         n.armed = 1; n.kind = 0; n.line = 0;
         return n;
      end
      if (!en || mode == 2'b11) n.kind = 0;
      else if (mode == 2'b00) begin n.kind = 1; n.line = s; end
      else if (mode == 2'b01) begin n.kind = load ? 2 : 0; n.line = s; end
      else begin
         if (m.kind != 3) begin
            n.p = 0; n.d = int'(dwell);
         end else begin
            n.p = m.p + 1;
            if (n.p == outw * (m.d + 1)) begin
               n.p = 0; n.d = int'(dwell); n.wrap = 1;
            end
         end
         n.kind = 3;
         n.line = n.p / (n.d + 1);
      end
      return n;
   endfunction

   function automatic logic [17:0] expect_of(mdl_t m, int outw, bit al);
      logic [7:0] v = '0;
      logic [7:0] mask = 8'((1 << outw) - 1);
      int idx = (m.kind != 0) ? m.line : 0;
      if (m.kind != 0) v[m.line] = 1'b1;
      if (al) v = ~v;
      v = v & mask;
      return {m.kind != 0, m.wrap, 8'(idx), v};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Advance the model on the same edges as the DUTs.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ma <= mdl_reset();
         mb <= mdl_reset();
      end else begin
         ma <= step(ma, 4, int'(sel_a));
         mb <= step(mb, 8, int'(sel_b));
      end
   end

   // Every-cycle comparison on the falling edge; also checks one-hotness.
   always @(negedge clk) begin
      chk("model_a {valid,wrap,idx,y}", 32'({valid_a, wrap_a, 8'(idx_a), 8'(y_a)}),
          32'(expect_of(ma, 4, 1'b1)));
      chk("model_b {valid,wrap,idx,y}", 32'({valid_b, wrap_b, 8'(idx_b), y_b}),
          32'(expect_of(mb, 8, 1'b0)));
      chk("onehot_a", 32'($countones(~y_a) <= 1), 32'd1);
      chk("onehot_b", 32'($countones(y_b) <= 1), 32'd1);
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic [3:0] ea;
      logic [7:0] eb;
      int ln;

      cyc(); cyc();
      chk("reset_y_a", 32'(y_a), 32'h0000000F);
      chk("reset_y_b", 32'(y_b), 32'h00000000);
      chk("reset_valid_a", 32'(valid_a), 32'd0);
      rst_n = 1'b1;

      // STATIC: first edge after release only arms the block.
      en = 1'b1; mode = 2'b00; sel_a = 2'd0; sel_b = 3'd5;
      cyc();
      chk("arm_edge_idle_a", 32'(y_a), 32'h0000000F);
      for (int i = 0; i < 4; i++) begin
         cyc();
         ea = 4'hF; ea[i] = 1'b0;
         chk("static_y_a", 32'(y_a), 32'(ea));
         chk("static_idx_a", 32'(idx_a), 32'(i));
         chk("static_valid_a", 32'(valid_a), 32'd1);
         sel_a = 2'(i + 1);
      end
      chk("static_sel5_b", 32'(y_b), 32'h00000020);

      sel_a = 2'd2;
      cyc();
      chk("static_sel2_a", 32'(y_a), 32'h0000000B);
      en = 1'b0;
      cyc();
      chk("en0_y_a", 32'(y_a), 32'h0000000F);
      chk("en0_valid_a", 32'(valid_a), 32'd0);
      en = 1'b1;
      cyc();
      chk("en1_y_a", 32'(y_a), 32'h0000000B);

      // PULSE: single strobe then continuous strobe.
      mode = 2'b01; sel_a = 2'd3; load = 1'b1;
      cyc();
      chk("pulse1_y_a", 32'(y_a), 32'h00000007);
      load = 1'b0;
      cyc();
      chk("pulse1_end_y_a", 32'(y_a), 32'h0000000F);
      load = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("pulse3_y_a", 32'(y_a), 32'h00000007);
      end
      load = 1'b0;
      cyc();
      chk("pulse3_end_y_a", 32'(y_a), 32'h0000000F);

      mode = 2'b11;
      cyc();
      chk("reserved_valid_a", 32'(valid_a), 32'd0);

      // SCAN dwell=2, dwell dropped to 0 mid-frame (applies after the wrap).
      mode = 2'b10; dwell = 4'd2;
      for (int c = 0; c < 17; c++) begin
         cyc();
         ln = (c < 12) ? c / 3 : (c - 12) % 4;
         ea = 4'hF; ea[ln] = 1'b0;
         chk("scan_d2_y_a", 32'(y_a), 32'(ea));
         chk("scan_d2_wrap_a", 32'(wrap_a), 32'(c == 12 || c == 16));
         if (c == 5) dwell = 4'd0;
      end

      // Abort into STATIC, rescan with dwell=1, reset while on line 2.
      mode = 2'b00; sel_a = 2'd1;
      cyc();
      mode = 2'b10; dwell = 4'd1;
      for (int c = 0; c < 5; c++) cyc();
      chk("scan_d1_line2_a", 32'(y_a), 32'h0000000B);
      rst_n = 1'b0;
      #1;
      chk("async_rst_y_a", 32'(y_a), 32'h0000000F);
      chk("async_rst_idx_a", 32'(idx_a), 32'd0);
      chk("async_rst_y_b", 32'(y_b), 32'h00000000);
      @(posedge clk);
      #2 rst_n = 1'b1;
      cyc();
      chk("rel_arm_idle_a", 32'(y_a), 32'h0000000F);
      cyc();
      chk("rel_scan_y_a", 32'(y_a), 32'h0000000E);
      chk("rel_scan_wrap_a", 32'(wrap_a), 32'd0);

      // SCAN dwell=0: 4-cycle frame on A, 8-cycle frame on B.
      mode = 2'b00;
      cyc();
      mode = 2'b10; dwell = 4'd0;
      for (int c = 0; c < 17; c++) begin
         cyc();
         eb = 8'd1 << (c % 8);
         chk("scan_d0_y_b", 32'(y_b), 32'(eb));
         chk("scan_d0_wrap_b", 32'(wrap_b), 32'(c == 8 || c == 16));
         chk("scan_d0_wrap_a", 32'(wrap_a), 32'(c > 0 && c % 4 == 0));
      end

      // SCAN dwell all ones: 16 cycles per line.
      mode = 2'b00;
      cyc();
      mode = 2'b10; dwell = 4'hF;
      for (int c = 0; c < 34; c++) begin
         cyc();
         ea = 4'hF; ea[c / 16] = 1'b0;
         chk("scan_dmax_y_a", 32'(y_a), 32'(ea));
      end

      // Mixed traffic, model-checked only.
      for (int i = 0; i < 150; i++) begin
         en    = ($urandom_range(0, 7) != 0);
         mode  = 2'($urandom_range(0, 3));
         sel_a = 2'($urandom);
         sel_b = 3'($urandom);
         load  = 1'($urandom);
         dwell = 4'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) for (int k = 0; k < 6; k++) cyc();
         else cyc();
      end

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
